// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - sizing helpers and rounding encodings for sqrt_stream
package sqrt_pkg;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_NEAREST = 1;

   // Integer bits of the root: half the radicand width, rounded up
   function automatic int out_int_w(input int in_w);
      return (in_w + 1) / 2;
   endfunction

   // Pipeline depth: resolved bits (result plus optional guard) spread over UNROLL-wide stages
   function automatic int num_stages(input int out_w, input int unroll, input int rnd);
      if (unroll < 1) begin
         return 1;
      end
      return (out_w + rnd + unroll - 1) / unroll;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring square-root step
module sqrt_step
   import sqrt_pkg::*;
#(
   parameter int Q_W  = 13,
   parameter int STEP = 0
) (
   input  logic [2*Q_W-1:0] rad,
   input  logic [Q_W+1:0]   rem_in,
   input  logic [Q_W-1:0]   q_in,
   output logic [Q_W+1:0]   rem_out,
   output logic [Q_W-1:0]   q_out
);

   // Step STEP consumes radicand bit pair STEP counted from the top
   localparam int PAIR_LSB = 2 * (Q_W - 1 - STEP);

   logic [Q_W+3:0] window;
   logic [Q_W+3:0] trial;
   logic           take;
   logic           unused_bits;

   // Two spare bits above the window make a negative trial show up as a set top bit
   assign window      = {rem_in, rad[PAIR_LSB +: 2]};
   assign trial       = window - {2'b00, q_in, 2'b01};
   assign take        = ~trial[Q_W+3];
   assign rem_out     = take ? trial[Q_W+1:0] : window[Q_W+1:0];
   assign q_out       = {q_in[Q_W-2:0], take};

   // Remainder and root never reach these bits; only one radicand pair is needed here
   assign unused_bits = ^{trial[Q_W+2], window[Q_W+3:Q_W+2], rad};

endmodule

// File: rtl/sqrt_stream.sv
// rtl/sqrt_stream.sv - pipelined streaming fixed-point square root with handshake
module sqrt_stream
   import sqrt_pkg::*;
#(
   parameter int IN_W   = 18,
   parameter int OUT_F  = 4,
   parameter int UNROLL = 1,
   parameter int ROUND  = ROUND_TRUNC,
   parameter int TAG_W  = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [IN_W-1:0]                       in_data,
   input  logic [TAG_W-1:0]                      in_tag,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [out_int_w(IN_W)+OUT_F-1:0]      out_data,
   output logic [TAG_W-1:0]                      out_tag,
   output logic                                  out_exact
);

   localparam int OUT_I = out_int_w(IN_W);
   localparam int OUT_W = OUT_I + OUT_F;
   localparam int RB    = OUT_W + ROUND;
   localparam int RAD_W = 2 * RB;
   localparam int NS    = num_stages(OUT_W, UNROLL, ROUND);
   localparam int NR    = (NS > 1) ? NS - 1 : 1;
   localparam int SHIFT = 2 * (OUT_W - OUT_I) + 2 * ROUND;

   if (UNROLL < 1 || UNROLL > RB || IN_W > 2 * OUT_W ||
       (ROUND != ROUND_TRUNC && ROUND != ROUND_NEAREST)) begin : g_bad_cfg
      $error("sqrt_stream: illegal UNROLL/ROUND/IN_W combination");
   end

   logic               adv;
   logic [RAD_W-1:0]   rad_in;

   logic               s_valid [NS];
   logic [RAD_W-1:0]   s_rad   [NS];
   logic [TAG_W-1:0]   s_tag   [NS];
   logic [RB+1:0]      c_rem   [NS][UNROLL+1];
   logic [RB-1:0]      c_q     [NS][UNROLL+1];

   logic               r_valid [NR];
   logic [RAD_W-1:0]   r_rad   [NR];
   logic [TAG_W-1:0]   r_tag   [NR];
   logic [RB+1:0]      r_rem   [NR];
   logic [RB-1:0]      r_q     [NR];

   logic [RB-1:0]      fin_q;
   logic [RB+1:0]      fin_rem;
   logic [OUT_W-1:0]   res_data;
   logic               res_exact;

   // The whole pipe moves as one; it only stalls when a held result is refused
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign rad_in   = RAD_W'(in_data) << SHIFT;

   for (genvar s = 0; s < NS; s++) begin : g_stage
      if (s == 0) begin : g_src
         assign s_valid[0]  = in_valid;
         assign s_rad[0]    = rad_in;
         assign s_tag[0]    = in_tag;
         assign c_rem[0][0] = '0;
         assign c_q[0][0]   = '0;
      end else begin : g_src
         assign s_valid[s]  = r_valid[s-1];
         assign s_rad[s]    = r_rad[s-1];
         assign s_tag[s]    = r_tag[s-1];
         assign c_rem[s][0] = r_rem[s-1];
         assign c_q[s][0]   = r_q[s-1];
      end
      for (genvar u = 0; u < UNROLL; u++) begin : g_step
         if (s * UNROLL + u < RB) begin : g_live
            sqrt_step #(
               .Q_W  (RB),
               .STEP (s * UNROLL + u)
            ) u_step (
               .rad     (s_rad[s]),
               .rem_in  (c_rem[s][u]),
               .q_in    (c_q[s][u]),
               .rem_out (c_rem[s][u+1]),
               .q_out   (c_q[s][u+1])
            );
         end else begin : g_pass
            assign c_rem[s][u+1] = c_rem[s][u];
            assign c_q[s][u+1]   = c_q[s][u];
         end
      end
   end

   assign fin_q   = c_q[NS-1][UNROLL];
   assign fin_rem = c_rem[NS-1][UNROLL];

   if (ROUND == ROUND_NEAREST) begin : g_round
      logic [OUT_W:0] sum;
      // Guard bit rounds ties up; a carry out of the top clamps to full scale
      assign sum       = {1'b0, fin_q[RB-1:1]} + {{OUT_W{1'b0}}, fin_q[0]};
      assign res_data  = sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
      assign res_exact = !fin_q[0] && (fin_rem == '0);
   end else begin : g_trunc
      assign res_data  = fin_q;
      assign res_exact = (fin_rem == '0);
   end

   // Stage registers plus the output register; reset clears valids and visible outputs only
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            r_valid[i] <= 1'b0;
         end
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_exact <= 1'b0;
      end else if (adv) begin
         for (int i = 0; i < NS - 1; i++) begin
            r_valid[i] <= s_valid[i];
            r_rad[i]   <= s_rad[i];
            r_tag[i]   <= s_tag[i];
            r_rem[i]   <= c_rem[i][UNROLL];
            r_q[i]     <= c_q[i][UNROLL];
         end
         out_valid <= s_valid[NS-1];
         out_data  <= res_data;
         out_tag   <= s_tag[NS-1];
         out_exact <= res_exact;
      end
   end

endmodule

// File: doc/sqrt_stream.md
# sqrt_stream

Streaming fixed-point square root with valid/ready handshake, synchronous reset, configurable bits-per-stage unrolling, optional round-to-nearest with saturation, a pass-through tag and an exactness flag. It is the parametrised successor to the free-running pipelined sqrt, which has no handshake and no reset. It sits behind the gradient-magnitude datapath, where sums of squared gradients are converted to magnitudes before binning. Downstream binning may stall it.

## Interface
- IN_W, 18: unsigned radicand width.
- OUT_F, 4: fractional bits of the result.
- OUT_I, derived: ceil(IN_W/2), integer bits of the result.
- OUT_W, derived: OUT_I + OUT_F.
- UNROLL, 1: result bits resolved per pipeline stage, 1..OUT_W.
- ROUND, 0: 0 truncates; 1 rounds to nearest, ties up, saturating.
- TAG_W, 8: width of the sideband carried alongside each sample.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  radicand present.
- in_ready  out  1  block accepts radicand this cycle.
- in_data  in  IN_W  unsigned radicand.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  unsigned result, OUT_F fraction bits.
- out_tag  out  TAG_W  tag of this result.
- out_exact  out  1  remainder zero and no rounding applied.

## Operation
- Radicand aligned: in_data << (2*OUT_W − 2*OUT_I); the aligned radicand is 2*OUT_W bits.
- ROUND=1 resolves one extra guard bit. Resolved bits RB = OUT_W + ROUND.
- Digit-by-digit restoring square root, one bit per step. For each step:
  - trial = remainder_window − {q, 2'b01}.
  - If trial ≥ 0: q ← {q, 1}, remainder ← trial.
  - Otherwise: q ← {q, 0}, remainder unchanged.
- The remainder is kept at RB+2 bits, so the window never truncates.
- Stage count NS = ceil(RB/UNROLL). Each stage chains UNROLL steps combinationally; the last stage chains the leftover steps.
- ROUND=1: out = q[RB−1:1] + q[0].
  - An all-ones carry saturates to 2^OUT_W − 1.
  - out_exact = 0 whenever the guard bit is 1 or saturation occurs.
- ROUND=0: out_exact = (final remainder == 0).
- in_data = 0 gives out_data = 0 and out_exact = 1.
- Handshake:
  - Each stage register holds a valid bit, q, remainder and tag.
  - adv = !out_valid || out_ready. All stages advance together when adv = 1 and hold when adv = 0.
  - in_ready = adv. Combinational from out_ready and out_valid.
  - Bubbles are not collapsed.
  - A transfer occurs when valid && ready on the same edge.
  - in_valid low while adv = 1 inserts a bubble (valid = 0).
- Results leave in input order. The tag stays aligned with its data.

## Timing
- Latency is NS cycles from the accepting edge to out_valid high, with no stall.
- Example: IN_W=18, OUT_F=4, UNROLL=1, ROUND=0 gives 13 cycles.
- Throughput is one result per cycle while out_ready = 1.
- While out_valid && !out_ready: out_data, out_tag and out_exact hold stable, and in_ready = 0.
- Reset:
  - All stage valid bits clear, so out_valid = 0 and in_ready = 1 the cycle after rst.
  - out_data, out_tag and out_exact reset to 0.
  - Datapath registers other than the outputs need not reset.
- Reset mid-stream discards all in-flight samples. No result from before reset emerges afterwards.
- rst has priority over a simultaneous handshake. A sample offered while rst = 1 is not accepted.
- Simultaneous output pop and input push under full occupancy both complete in the same cycle.

## Structure
- Package sqrt_pkg holds:
  - function out_int_w(IN_W);
  - function num_stages(OUT_W, UNROLL, ROUND);
  - localparam encodings ROUND_TRUNC = 0 and ROUND_NEAREST = 1.
- Sub-module sqrt_step: one combinational restoring step.
  - Parameters: Q_W, step index.
  - Inputs: remainder, q.
  - Outputs: remainder', q'.
  - Instantiated UNROLL times per stage by generate.
- Top level contains the stage registers, the valid/advance logic, and the round/saturate/exact output stage folded into the last stage register.
- Elaboration error when UNROLL < 1, UNROLL > RB, or IN_W > 2*OUT_W.

## Test plan
- Defaults, ROUND=0:
  - in 0 gives 0x0000 with exact=1.
  - in 16 gives 0x0040 with exact=1.
  - in 2 gives 0x0016 (1.375) with exact=0.
  - Latency is 13 cycles.
- ROUND=1: in 2 gives 0x0017. in 262143 saturates to 0x1FFF with exact=0.
- UNROLL=4, ROUND=0: in 100 gives 0x00A0. Latency ceil(13/4) = 4. Back-to-back stream of 64 random values matches a reference model, with in_ready constantly 1.
- Backpressure:
  - Stream tags 1..20, with out_ready low for cycles 15–19 after the first accept.
  - out_data and out_tag stay frozen while stalled. in_ready = 0 in those cycles.
  - No loss or duplication; tags emerge in order.
- Bubbles: toggle in_valid randomly at 50%. Every accepted tag appears exactly once, in order, with correct data.
- Reset mid-operation:
  - Assert rst one cycle with 5 samples in flight.
  - out_valid = 0 from the next cycle, with zero outputs.
  - The first post-reset sample (in 9, expected 0x0030) is the only one that emerges.
